// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the I-cache refill path and the
//   D-cache refill/write-back path. One requester owns the port for a whole
//   cache-line burst of BEATS words; under contention ownership alternates.
//
//   Optional build macro: MEM_ARB_TIMEOUT_EN
//     defined   -> per-beat wait counter aborts a stalled burst with a
//                  one-cycle err pulse after TIMEOUT_CYCLES cycles.
//     undefined -> err tied low, a burst waits indefinitely for mem_ready.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | port free; arbitrate i_req/d_req, latch base address and we
//   BUSY    | burst in flight for owner; one beat per mem_ready

module mem_port_arbiter #(
  parameter int LINE_BYTES     = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_last,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_last,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int BEATS  = LINE_BYTES / 4;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [0:0]        state_q;
  logic              owner_q;
  logic              last_owner_q;
  logic [BEAT_W-1:0] beat_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;

  logic busy;
  logic grant_i;
  logic grant_d;
  logic beat_done;
  logic burst_done;
  logic timeout_hit;

  assign busy = (state_q == ST_BUSY);

  // Tie goes to whichever side did not own the port last.
  assign grant_i = !busy && i_req && (!d_req || (last_owner_q == OWN_D));
  assign grant_d = !busy && d_req && (!i_req || (last_owner_q == OWN_I));

  assign beat_done  = busy && mem_ready;
  assign burst_done = beat_done && (beat_q == LAST_BEAT);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_q;

  // Down-counter over the cycles of the current beat; reloads on grant and on every mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else if (grant_i || grant_d || beat_done) begin
      wait_q <= TO_LOAD;
    end else if (busy && (wait_q != '0)) begin
      wait_q <= wait_q - 1'b1;
    end
  end

  assign timeout_hit = busy && !mem_ready && (wait_q == '0);
  assign err         = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Arbitration, burst sequencing and ownership bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_D;
      beat_q       <= '0;
      base_q       <= '0;
      we_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_i) begin
            state_q <= ST_BUSY;
            owner_q <= OWN_I;
            base_q  <= i_addr & LINE_MASK;
            we_q    <= 1'b0;
            beat_q  <= '0;
          end else if (grant_d) begin
            state_q <= ST_BUSY;
            owner_q <= OWN_D;
            base_q  <= d_addr & LINE_MASK;
            we_q    <= d_we;
            beat_q  <= '0;
          end
        end
        ST_BUSY: begin
          if (burst_done || timeout_hit) begin
            state_q      <= ST_IDLE;
            last_owner_q <= owner_q;
            beat_q       <= '0;
          end else if (beat_done) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

  // Memory side is a pure decode of the registered burst state, so a reset
  // drops mem_req in the same cycle it is asserted.
  assign mem_req   = busy;
  assign mem_we    = busy && we_q;
  assign mem_addr  = busy ? (base_q + ADDR_W'({beat_q, 2'b00})) : '0;
  assign mem_wdata = (busy && (owner_q == OWN_D)) ? d_wdata : 32'h0;

  assign i_ack  = beat_done && (owner_q == OWN_I);
  assign d_ack  = beat_done && (owner_q == OWN_D);
  assign i_last = i_ack && (beat_q == LAST_BEAT);
  assign d_last = d_ack && (beat_q == LAST_BEAT);

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes the expected beats,
// a negedge monitor pops one entry per ack and compares it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, i_last, d_ack, d_last, mem_req, mem_we, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int vectors = 0;
  int nmis    = 0;

  typedef struct {
    logic        side;   // 0 = I, 1 = D
    logic        last;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  mem_port_arbiter #(.LINE_BYTES(32), .ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_last(i_last), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_last(d_last), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input logic side, input logic [31:0] base, input logic we,
                            input int k0, input int nbeats);
    exp_t e;
    for (int b = 0; b < nbeats; b++) begin
      e.side  = side;
      e.last  = (b == 7);
      e.addr  = base + 32'(4 * b);
      e.we    = we;
      e.wdata = 32'hA0 + 32'(b);
      e.rdata = 32'h5A00_0000 + 32'(k0 + b);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: one scoreboard entry per beat acknowledged to either cache.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (i_last && !i_ack) begin nmis++; $display("FAIL i_last_without_ack at %0t", $time); end
      if (d_last && !d_ack) begin nmis++; $display("FAIL d_last_without_ack at %0t", $time); end
      if (i_ack && d_ack) begin
        nmis++; $display("FAIL dual_ack: i_ack and d_ack both 1 at %0t", $time);
      end else if (i_ack || d_ack) begin
        if (sb_q.size() == 0) begin
          nmis++;
          $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b addr=0x%08h at %0t", i_ack, d_ack, mem_addr, $time);
        end else begin
          e = sb_q.pop_front();
          chk("ack_side", {31'b0, d_ack}, {31'b0, e.side});
          chk("last_flag", {31'b0, (d_ack ? d_last : i_last)}, {31'b0, e.last});
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_req_on_ack", {31'b0, mem_req}, 32'd1);
          chk("rdata", (d_ack ? d_rdata : i_rdata), e.rdata);
          if (e.side) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
    end
  end

  // Drives one or two requesters until their bursts complete (or aborts by reset).
  task automatic run(input logic wi, input logic wd, input logic [31:0] ia, input logic [31:0] da,
                     input logic dwe, input bit toggle, input int drop_i_after,
                     input int abort_at, input bit chk_lat);
    int bi = 0, bd = 0, lasts = 0, need;
    bit prev_last = 0, i_done = 0, d_done = 0, done = 0;
    need = int'(wi) + int'(wd);
    i_req = wi; d_req = wd; i_addr = ia; d_addr = da; d_we = dwe;
    mem_ready = 1'b1; d_wdata = 32'hA0; mem_rdata = 32'h5A00_0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (chk_lat && cyc == 0) chk("lat_idle_mem_req", {31'b0, mem_req}, 32'd0);
      if (chk_lat && cyc == 1) chk("lat_grant_mem_req", {31'b0, mem_req}, 32'd1);
      if (prev_last) chk("idle_gap_mem_req", {31'b0, mem_req}, 32'd0);
      prev_last = 0;
      if (i_ack) begin bi++; if (i_last) begin lasts++; prev_last = 1; i_done = 1; end end
      if (d_ack) begin bd++; if (d_last) begin lasts++; prev_last = 1; d_done = 1; end end
      if (lasts == need) begin done = 1; break; end
      @(posedge clk); #1;
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
      if (drop_i_after >= 0 && bi >= drop_i_after) begin i_req = 1'b0; i_addr = 32'hFFFF_FFFC; end
      if (toggle) mem_ready = ~mem_ready;
      d_wdata   = 32'hA0 + 32'(bd);
      mem_rdata = 32'h5A00_0000 + 32'(bi + bd);
      if (abort_at >= 0 && bd == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        return;
      end
    end
    if (!done) begin
      nmis++;
      $display("FAIL burst_timeout: lasts seen %0d expected %0d", lasts, need);
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_acks", {28'b0, i_ack, i_last, d_ack, d_last}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // mem_ready while idle must not produce acks
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_no_ack", {30'b0, i_ack, d_ack}, 32'd0);
    end
    @(posedge clk); #1; mem_ready = 1'b0;

    // 1: I-side refill, offset bits dropped
    push_burst(1'b0, 32'h1000, 1'b0, 0, 8);
    run(1, 0, 32'h1004, 0, 0, 0, -1, -1, 1);

    // 2: D-side write-back
    push_burst(1'b1, 32'h2000, 1'b1, 0, 8);
    run(0, 1, 0, 32'h2000, 1, 0, -1, -1, 1);

    // 3: contention, last owner D -> I first, then D
    push_burst(1'b0, 32'h3000, 1'b0, 0, 8);
    push_burst(1'b1, 32'h3100, 1'b0, 8, 8);
    run(1, 1, 32'h3008, 32'h3104, 0, 0, -1, -1, 1);
    // single I burst makes I the last owner
    push_burst(1'b0, 32'h3200, 1'b0, 0, 8);
    run(1, 0, 32'h3200, 0, 0, 0, -1, -1, 1);
    // contention again -> D first now
    push_burst(1'b1, 32'h3300, 1'b1, 0, 8);
    push_burst(1'b0, 32'h3400, 1'b0, 8, 8);
    run(1, 1, 32'h3400, 32'h3300, 1, 0, -1, -1, 1);

    // 4: mem_ready toggling, i_req and i_addr disturbed after beat 3
    push_burst(1'b0, 32'h4000, 1'b0, 0, 8);
    run(1, 0, 32'h4018, 0, 0, 1, 4, -1, 1);

    // 5: reset during beat 4 of a D burst, then a fresh burst from beat 0
    push_burst(1'b1, 32'h2C00, 1'b0, 0, 4);
    run(0, 1, 0, 32'h2C10, 0, 0, -1, 4, 1);
    @(posedge clk); #1;
    i_req = 0; d_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("reset_hold_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    push_burst(1'b1, 32'h2C00, 1'b0, 0, 8);
    run(0, 1, 0, 32'h2C10, 0, 0, -1, -1, 1);

    // 6: stalled memory
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000; mem_ready = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      chk("timeout_err", {31'b0, err}, {31'b0, (c == 16)});
      if (c == 17) chk("timeout_mem_req", {31'b0, mem_req}, 32'd0);
      @(posedge clk); #1;
      if (c == 16) d_req = 1'b0;
    end
`else
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("no_timeout_err", {31'b0, err}, 32'd0);
      if (c > 0) chk("stall_mem_req", {31'b0, mem_req}, 32'd1);
      @(posedge clk); #1;
    end
    push_burst(1'b1, 32'h6000, 1'b0, 0, 8);
    run(0, 1, 0, 32'h6000, 0, 0, -1, -1, 0);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
